// File: rtl/pixel_framebuffer_if.sv
//==============================================================================
// pixel_framebuffer_if: plot-side write bus and raster scan-out bus of the
// frame buffer. Rev 1.0
//==============================================================================
`default_nettype none

interface pixel_framebuffer_if;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        clear;
  logic [2:0]  bg_colour;
  logic        busy;
  logic [2:0]  pix_colour;
  logic        pix_valid;
  logic        line_start;
  logic        frame_start;
  logic [15:0] dropped;

  modport master (
    output x, y, colour, writeEn, clear, bg_colour,
    input  busy, pix_colour, pix_valid, line_start, frame_start, dropped
  );

  modport slave (
    input  x, y, colour, writeEn, clear, bg_colour,
    output busy, pix_colour, pix_valid, line_start, frame_start, dropped
  );
endinterface

`default_nettype wire

// File: rtl/pixel_framebuffer.sv
//==============================================================================
// pixel_framebuffer: on-chip frame store with a plot write port, hardware clear
// to a background colour and continuous raster scan-out. Rev 1.0
//==============================================================================
`default_nettype none

module pixel_framebuffer #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int H_TOTAL = 200,
  parameter int V_TOTAL = 130
) (
  input wire               clk,
  input wire               reset,
  pixel_framebuffer_if.slave bus
);

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW     = $clog2(H_TOTAL);
  localparam int VW     = $clog2(V_TOTAL);

  localparam logic [8:0]        X_LIM       = 9'(WIDTH);
  localparam logic [7:0]        Y_LIM       = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(WIDTH);
  localparam logic [HW-1:0]     H_ACT       = HW'(WIDTH);
  localparam logic [HW-1:0]     H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT       = VW'(HEIGHT);
  localparam logic [VW-1:0]     V_LAST      = VW'(V_TOTAL - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [2:0]        w_mem_data;
  logic              w_drop;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_plot_addr;

  logic [2:0]        r_mem [DEPTH];
  logic [2:0]        r_rd_data;
  logic [ADDR_W-1:0] w_rd_addr;

  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic              w_active;

  logic              r_s1_valid;
  logic              r_s1_line;
  logic              r_s1_frame;
  logic [2:0]        r_pix_colour;
  logic              r_pix_valid;
  logic              r_line_start;
  logic              r_frame_start;
  logic [15:0]       r_dropped;

  assign w_in_range  = ({1'b0, bus.x} < X_LIM) && ({1'b0, bus.y} < Y_LIM);
  assign w_plot_addr = ADDR_W'(bus.y) * LINE_STRIDE + ADDR_W'(bus.x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // The clear owns the single memory write port; plots arriving meanwhile are dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_mem_we       = 1'b0;
    w_mem_addr     = w_plot_addr;
    w_mem_data     = bus.colour;
    w_drop         = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clr_addr;
        w_mem_data = bus.bg_colour;
        w_drop     = bus.writeEn;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt    = ST_IDLE;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
          w_drop         = bus.writeEn;
        end else if (bus.writeEn) begin
          if (w_in_range) begin
            w_mem_we = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dropped <= '0;
    end else if (w_drop && (r_dropped != 16'hFFFF)) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_rd_addr = w_active ? (ADDR_W'(r_v) * LINE_STRIDE + ADDR_W'(r_h)) : '0;

  // Frame store is not reset; a same-address read in the write cycle returns old data.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_line     <= 1'b0;
      r_s1_frame    <= 1'b0;
      r_pix_colour  <= 3'd0;
      r_pix_valid   <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_s1_valid    <= w_active;
      r_s1_line     <= w_active && (r_h == '0);
      r_s1_frame    <= (r_h == '0) && (r_v == '0);
      r_pix_colour  <= r_s1_valid ? r_rd_data : 3'd0;
      r_pix_valid   <= r_s1_valid;
      r_line_start  <= r_s1_line;
      r_frame_start <= r_s1_frame;
    end
  end

  assign bus.busy        = (r_state == ST_CLEAR);
  assign bus.pix_colour  = r_pix_colour;
  assign bus.pix_valid   = r_pix_valid;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.dropped     = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_pixel_framebuffer.sv
//==============================================================================
// tb_pixel_framebuffer: directed self-checking bench for pixel_framebuffer.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pixel_framebuffer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HT = 10;
  localparam int VT = 6;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [2:0] exp_mem [W*H];

  pixel_framebuffer_if bus ();

  pixel_framebuffer #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .H_TOTAL (HT),
    .V_TOTAL (VT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_exp(input logic [2:0] c);
    for (int i = 0; i < W*H; i++) exp_mem[i] = c;
  endtask

  task automatic plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
    bus.x       = px;
    bus.y       = py;
    bus.colour  = c;
    bus.writeEn = 1'b1;
    @(negedge clk);
    bus.writeEn = 1'b0;
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Checks one whole frame: colour, valid, line/frame markers at every scan slot.
  task automatic check_frame(input string tag);
    bit ok;
    int lines;
    int hh;
    int vv;
    bit act;
    logic [5:0] got;
    logic [5:0] exp;
    wait_frame_start(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_frame_start_timeout: got none required frame_start within 200 cycles", tag);
    end
    lines = 0;
    for (int k = 0; k < HT*VT; k++) begin
      if (k > 0) @(negedge clk);
      hh  = k % HT;
      vv  = k / HT;
      act = (hh < W) && (vv < H);
      exp = {act, (act && hh == 0), (k == 0), (act ? exp_mem[vv*W + hh] : 3'd0)};
      got = {bus.pix_valid, bus.line_start, bus.frame_start, bus.pix_colour};
      if (bus.line_start === 1'b1) lines++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_pixel h=%0d v=%0d: got {valid,line,frame,colour}=%b required %b",
                 tag, hh, vv, got, exp);
      end
    end
    checks++;
    if (lines != H) begin
      failures++;
      $display("FAIL %s_line_count: got %0d required %0d", tag, lines, H);
    end
  endtask

  // Called at a negedge with reset high: releases it and tracks the clear and first pixel.
  task automatic release_and_check(input string tag);
    int cnt;
    reset = 1'b0;
    cnt   = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        checks++;
        if (bus.frame_start !== 1'b0) begin
          failures++;
          $display("FAIL %s_edge1_frame_start: got %b required 0", tag, bus.frame_start);
        end
      end
      if (cnt == 2) begin
        checks++;
        if ({bus.frame_start, bus.pix_valid} !== 2'b11) begin
          failures++;
          $display("FAIL %s_edge2_first_pixel: got {frame,valid}=%b required 11",
                   tag, {bus.frame_start, bus.pix_valid});
        end
      end
    end
    checks++;
    if (cnt != W*H) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", tag, cnt, W*H);
    end
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_timeout: got busy=%b required 0", tag, bus.busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b required 1", bus.busy);
    end
    checks++;
    if ({bus.pix_valid, bus.line_start, bus.frame_start, bus.pix_colour} !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {bus.pix_valid, bus.line_start, bus.frame_start, bus.pix_colour});
    end
    checks++;
    if (bus.dropped !== 16'd0) begin
      failures++;
      $display("FAIL reset_dropped: got %0d required 0", bus.dropped);
    end
    release_and_check("reset");
    fill_exp(3'd2);
    check_frame("clear_bg2");
  endtask

  task automatic test_plot();
    plot(8'd3, 7'd2, 3'd5);
    exp_mem[2*W + 3] = 3'd5;
    plot(8'd7, 7'd3, 3'd7);
    exp_mem[3*W + 7] = 3'd7;
    check_frame("plot");
    checks++;
    if (bus.dropped !== 16'd0) begin
      failures++;
      $display("FAIL plot_dropped: got %0d required 0", bus.dropped);
    end
  endtask

  task automatic test_drop();
    plot(8'd8, 7'd0, 3'd1);
    plot(8'd0, 7'd4, 3'd1);
    check_frame("out_of_range");
    bus.bg_colour = 3'd2;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_busy_high: got %b required 1", bus.busy);
    end
    plot(8'd5, 7'd1, 3'd6);
    wait_idle("drop");
    fill_exp(3'd2);
    checks++;
    if (bus.dropped !== 16'd3) begin
      failures++;
      $display("FAIL drop_count: got %0d required 3", bus.dropped);
    end
    check_frame("write_while_busy");
  endtask

  task automatic test_clear_collision();
    int cnt;
    bus.bg_colour = 3'd4;
    bus.clear     = 1'b1;
    bus.x         = 8'd1;
    bus.y         = 7'd1;
    bus.colour    = 3'd5;
    bus.writeEn   = 1'b1;
    @(negedge clk);
    bus.writeEn = 1'b0;
    bus.clear   = 1'b0;
    cnt = 0;
    // A second clear request mid-clear must neither restart nor extend it.
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      bus.clear = (cnt == 10);
      @(negedge clk);
    end
    bus.clear = 1'b0;
    checks++;
    if (cnt != W*H) begin
      failures++;
      $display("FAIL collision_busy_cycles: got %0d required %0d", cnt, W*H);
    end
    checks++;
    if (bus.dropped !== 16'd4) begin
      failures++;
      $display("FAIL collision_dropped: got %0d required 4", bus.dropped);
    end
    fill_exp(3'd4);
    check_frame("collision");
  endtask

  task automatic test_reset_mid_clear();
    bus.bg_colour = 3'd1;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midclear_busy_in_reset: got %b required 1", bus.busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dropped, bus.pix_valid} !== 17'd0) begin
      failures++;
      $display("FAIL midclear_reset_values: got dropped=%0d valid=%b required 0/0",
               bus.dropped, bus.pix_valid);
    end
    bus.bg_colour = 3'd6;
    release_and_check("midclear");
    fill_exp(3'd6);
    check_frame("midclear");
  endtask

  task automatic test_read_during_write();
    bit ok;
    wait_frame_start(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rdw_frame_start_timeout: got none required frame_start within 200 cycles");
    end
    repeat (10) @(negedge clk);
    plot(8'd2, 7'd1, 3'd3);
    @(negedge clk);
    checks++;
    if ({bus.pix_valid, bus.pix_colour} !== {1'b1, 3'd6}) begin
      failures++;
      $display("FAIL rdw_old_data: got {valid,colour}=%b required 1110",
               {bus.pix_valid, bus.pix_colour});
    end
    exp_mem[1*W + 2] = 3'd3;
    check_frame("rdw_new_data");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.x         = 8'd0;
    bus.y         = 7'd0;
    bus.colour    = 3'd0;
    bus.writeEn   = 1'b0;
    bus.clear     = 1'b0;
    bus.bg_colour = 3'd2;
    fill_exp(3'd0);
    test_reset();
    test_plot();
    test_drop();
    test_clear_collision();
    test_reset_mid_clear();
    test_read_during_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- Receiving end of the (x, y, colour, writeEn) pixel-plot interface that our drawing blocks drive.
- Stores plotted pixels in an on-chip frame memory and continuously scans the memory out in raster order as a pixel stream with line and frame markers.
- Provides a hardware clear to a background colour; the clear runs automatically after reset.
- Sits between the drawing/FSM blocks (writers) and the display output stage (reader).

Parameters:
WIDTH, 160, active pixels per line (1..256)
HEIGHT, 120, active lines per frame (1..128)
H_TOTAL, 200, scan cycles per line including blanking (> WIDTH)
V_TOTAL, 130, scan lines per frame including blanking (> HEIGHT)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
x  in  8  write column
y  in  7  write row
colour  in  3  write colour
writeEn  in  1  plot strobe: one pixel per cycle while high
clear  in  1  request a clear to bg_colour; single-cycle pulse or level
bg_colour  in  3  clear colour, sampled every cycle of a clear
busy  out  1  high while a clear is in progress
pix_colour  out  3  scanned pixel colour; 0 when pix_valid is low
pix_valid  out  1  pix_colour is an active-region pixel
line_start  out  1  pulse with pixel (0, v) for each active line v
frame_start  out  1  pulse with pixel (0, 0)
dropped  out  16  saturating count of writes that were ignored

Behaviour:
- Memory: WIDTH*HEIGHT words of 3 bits; address = y*WIDTH + x. Memory contents are not reset; the clear defines them.
- Control FSM has two states, CLEAR and IDLE.
  - Reset forces CLEAR with clr_addr=0 and busy=1, so busy reads 1 during reset.
  - CLEAR: each cycle writes bg_colour to clr_addr, then increments clr_addr. Leaving the write at clr_addr = WIDTH*HEIGHT-1 moves to IDLE; busy falls on the next edge.
  - A clear lasts exactly WIDTH*HEIGHT cycles.
  - IDLE: clear=1 enters CLEAR with clr_addr=0.
  - Asserting reset mid-clear restarts the clear from address 0.
- Write port (IDLE only). On writeEn=1 with x<WIDTH and y<HEIGHT, the pixel is written at that edge. The write is dropped and dropped is incremented (saturating at 16'hFFFF) if any of these hold:
  - x>=WIDTH or y>=HEIGHT;
  - FSM is in CLEAR;
  - clear=1 in the same IDLE cycle (clear wins).
- clear while busy is ignored; there is no restart and no counting.
- Scan counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1):
  - h increments every cycle; when h wraps, v increments; v wraps to 0 after V_TOTAL-1.
  - Both counters reset to 0.
  - Scanning never stops, including during CLEAR and reset release.
- Active region: h<WIDTH and v<HEIGHT.
- Read pipeline latency is 2 cycles. Scan position sampled at edge t appears on all pixel outputs after edge t+2:
  - cycle 1 is the memory read;
  - cycle 2 is the output register.
- Outputs are fully registered: pix_colour, pix_valid, line_start, frame_start.
- Read-during-write to the same address returns the old data.
- Reset values of all outputs except busy are 0. busy resets to 1. dropped is cleared only by reset.
- The first pixel (0,0) appears with pix_valid=1 and frame_start=1 on the 2nd rising edge after reset is released.

Test Plan:
Use WIDTH=8, HEIGHT=4, H_TOTAL=10, V_TOTAL=6 unless noted.
1. Reset then bg_colour=3'b010 held:
   - busy=1 for 32 cycles after reset release, then 0;
   - the next full frame has pix_colour=2 on all 32 valid pixels;
   - pix_valid=0 during h 8..9 and v 4..5.
2. After the clear, plot (3,2,3'b101) and (7,3,3'b111), then wait one frame:
   - scan shows 5 at pixel (3,2) and 7 at pixel (7,3), all others 2;
   - frame_start coincides with pixel (0,0);
   - line_start fires 4 times per frame.
3. Out-of-range writes (8,0) and (0,4), plus a write while busy=1:
   - memory is unchanged;
   - dropped=3.
4. clear and writeEn=1 at (1,1) in the same IDLE cycle:
   - clear runs the full 32 cycles;
   - (1,1) holds bg_colour;
   - dropped increments by 1.
5. Assert reset at clr_addr=17 of a clear, then release:
   - busy stays high for a full 32 cycles;
   - scan counters restart, with frame_start on the 2nd edge after release.
6. Write address A while the scan reads A in the same cycle:
   - that pix_colour shows the old value;
   - the next frame shows the new value.
